// File: rtl/bar_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bar_ctrl_pkg
//  Description : Shared state encoding, widths and default unlock constants
//                for the BAR unlock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package bar_ctrl_pkg;

  localparam int c_STATE_W = 3;
  localparam int c_TIMER_W = 16;

  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_GOT1    = 3'd1,
    ST_GOT2    = 3'd2,
    ST_ENABLED = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [31:0] c_KEY0_DEFAULT  = 32'hA5A5_FF00;
  localparam logic [31:0] c_KEY1_DEFAULT  = 32'h5A5A_00FF;
  localparam logic [31:0] c_KEY2_DEFAULT  = 32'hC3C3_3C3C;
  localparam logic [31:0] c_DEACT_DEFAULT = 32'hDEAD_0000;

endpackage
`default_nettype wire

// File: rtl/bar_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bar_gap_timer
//  Description : 16-bit up/down counter with clear, load and a terminal-count
//                flag against a caller-supplied compare value. Serves both the
//                inter-word timeout (counting up) and the lockout (counting down).
//  Revision    : 1.0 - initial release
// ============================================================================
module bar_gap_timer
  import bar_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [c_TIMER_W-1:0] i_load_val,
  input  logic                 i_en,
  input  logic                 i_up,
  input  logic [c_TIMER_W-1:0] i_tc_val,
  output logic                 o_tc
);

  logic [c_TIMER_W-1:0] count_q;
  logic [c_TIMER_W-1:0] count_d;

  // Next count: clear beats load, load beats counting.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_en) begin
      count_d = i_up ? (count_q + 16'd1) : (count_q - 16'd1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = (count_q == i_tc_val);

endmodule
`default_nettype wire

// File: rtl/bar_unlock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bar_unlock_ctrl
//  Description : Three-word DMA unlock sequence gating BAR decode, with an
//                inter-word timeout, failure counting and timed lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module bar_unlock_ctrl
  import bar_ctrl_pkg::*;
#(
  parameter logic [31:0] KEY0           = c_KEY0_DEFAULT,
  parameter logic [31:0] KEY1           = c_KEY1_DEFAULT,
  parameter logic [31:0] KEY2           = c_KEY2_DEFAULT,
  parameter logic [31:0] DEACT_CODE     = c_DEACT_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dma_data,
  input  logic                 dma_valid,
  output logic                 bar_enabled,
  output logic                 unlock_pulse,
  output logic                 lockout,
  output logic [3:0]           fail_cnt,
  output logic [c_STATE_W-1:0] state_o
);

  // The timeout fires on the gap cycle where the timer would reach
  // TIMEOUT_CYCLES-1, i.e. while it still holds TIMEOUT_CYCLES-2.
  localparam logic [c_TIMER_W-1:0] c_TO_TC   = 16'(TIMEOUT_CYCLES - 2);
  localparam logic [c_TIMER_W-1:0] c_LO_LOAD = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [4:0]           c_MAX_F   = 5'(MAX_FAILS);

  state_t     state_q, state_d;
  logic [3:0] fail_cnt_q, fail_cnt_d;
  logic       bar_en_q, bar_en_d;
  logic       unlock_q, unlock_d;
  logic       lockout_q, lockout_d;

  logic                 w_tmr_clr;
  logic                 w_tmr_load;
  logic                 w_tmr_en;
  logic                 w_tmr_up;
  logic                 w_tmr_tc;
  logic [c_TIMER_W-1:0] w_tmr_tc_val;
  logic                 w_fail;
  logic [3:0]           w_fail_inc;

  assign w_tmr_tc_val = (state_q == ST_LOCKOUT) ? '0 : c_TO_TC;
  assign w_fail_inc   = (fail_cnt_q == 4'hF) ? 4'hF : (fail_cnt_q + 4'd1);

  bar_gap_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (c_LO_LOAD),
    .i_en       (w_tmr_en),
    .i_up       (w_tmr_up),
    .i_tc_val   (w_tmr_tc_val),
    .o_tc       (w_tmr_tc)
  );

  // Next-state, failure handling and timer control; a valid word always wins
  // over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    w_tmr_clr  = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_up   = 1'b1;
    w_fail     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dma_valid && (dma_data == KEY0)) begin
          state_d   = ST_GOT1;
          w_tmr_clr = 1'b1;
        end
      end
      ST_GOT1: begin
        if (dma_valid) begin
          if (dma_data == KEY1) begin
            state_d   = ST_GOT2;
            w_tmr_clr = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_tmr_tc) begin
          w_fail = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_GOT2: begin
        if (dma_valid) begin
          if (dma_data == KEY2) begin
            state_d    = ST_ENABLED;
            fail_cnt_d = '0;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_tmr_tc) begin
          w_fail = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_ENABLED: begin
        if (dma_valid && (dma_data == DEACT_CODE)) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_tc) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end else begin
          w_tmr_en = 1'b1;
          w_tmr_up = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_fail) begin
      fail_cnt_d = w_fail_inc;
      if (({1'b0, fail_cnt_q} + 5'd1) == c_MAX_F) begin
        state_d    = ST_LOCKOUT;
        w_tmr_load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    bar_en_d  = (state_d == ST_ENABLED);
    unlock_d  = (state_d == ST_ENABLED) && (state_q != ST_ENABLED);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fail_cnt_q <= '0;
      bar_en_q   <= 1'b0;
      unlock_q   <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      bar_en_q   <= bar_en_d;
      unlock_q   <= unlock_d;
      lockout_q  <= lockout_d;
    end
  end

  assign bar_enabled  = bar_en_q;
  assign unlock_pulse = unlock_q;
  assign lockout      = lockout_q;
  assign fail_cnt     = fail_cnt_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire
